// File: rtl/aes_pkg.sv
// Shared AES definitions: field polynomial, GF(2^8) constant multipliers
// built from xtime, and the iterative column-mix FSM state type.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } imc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] a);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(a)));
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] a);
    logic [7:0] x2;
    x2 = xtime(a);
    return xtime(xtime(x2)) ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] a);
    logic [7:0] x4;
    x4 = xtime(xtime(a));
    return xtime(x4) ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x4;
    x2 = xtime(a);
    x4 = xtime(x2);
    return xtime(x4) ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_columns_iter_word.sv
// Single-column InvMixColumns: byte 0 is the MSB of the 32-bit word.
module inv_mix_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] b0, b1, b2, b3;
  logic [7:0] m0, m1, m2, m3;

  always_comb begin
    b0 = col_in[31:24];
    b1 = col_in[23:16];
    b2 = col_in[15:8];
    b3 = col_in[7:0];
    m0 = gmul14(b0) ^ gmul11(b1) ^ gmul13(b2) ^ gmul9(b3);
    m1 = gmul9(b0)  ^ gmul14(b1) ^ gmul11(b2) ^ gmul13(b3);
    m2 = gmul13(b0) ^ gmul9(b1)  ^ gmul14(b2) ^ gmul11(b3);
    m3 = gmul11(b0) ^ gmul13(b1) ^ gmul9(b2)  ^ gmul14(b3);
    col_out = {m0, m1, m2, m3};
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns: one column per cycle through a shared word unit,
// with valid/ready handshakes on both sides.
module inv_mix_columns_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  imc_state_e      fsm;
  logic [1:0]      col;
  // Column 0 occupies the top word, so word index is 3 - col.
  logic [3:0][31:0] state_q;
  logic [31:0]     cur_word;
  logic [31:0]     mixed_word;

  assign cur_word = state_q[2'd3 - col];
  assign out_data = state_q;

  inv_mix_word u_word (
    .col_in  (cur_word),
    .col_out (mixed_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= ST_IDLE;
      col       <= '0;
      state_q   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            state_q  <= in_data;
            col      <= '0;
            in_ready <= 1'b0;
            fsm      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          state_q[2'd3 - col] <= mixed_word;
          col                 <= col + 2'd1;
          if (col == 2'd3) begin
            out_valid <= 1'b1;
            fsm       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          fsm       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Self-checking bench for inv_mix_columns_iter against a matrix-level
// GF(2^8) reference model.
module tb_inv_mix_columns_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int errors;
  int checks;

  inv_mix_columns_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-less product then polynomial long division by 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] mat_mix(input logic [127:0] s, input logic [31:0] coefs);
    logic [127:0] r;
    logic [7:0]   b [4];
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    r = '0;
    for (int k = 0; k < 4; k++) cf[k] = 8'((coefs >> (24 - 8 * k)) & 32'hFF);
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) b[k] = 8'((s >> (120 - 32 * c - 8 * k)) & 128'hFF);
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(cf[(k - row) & 3], b[k]);
        r = r | (128'(acc) << (120 - 32 * c - 8 * row));
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_inv_mix(input logic [127:0] s);
    return mat_mix(s, 32'h0E0B0D09);
  endfunction

  function automatic logic [127:0] ref_fwd_mix(input logic [127:0] s);
    return mat_mix(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drives one state in from IDLE, waits for out_valid, then completes the out handshake.
  task automatic transact(input logic [127:0] d, output logic [127:0] r, output int lat, output bit ok);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1 lat++;
    end
    r = out_data;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #23;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_column();
    logic [127:0] r; int lat; bit ok;
    transact(128'h8e4da1bc_01010101_01010101_01010101, r, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=none exp=out_valid"); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency got=%0d exp=4", lat); end
    checks++; if (r !== 128'hdb135345_01010101_01010101_01010101) begin
      errors++; $display("FAIL single_data got=%h exp=db135345010101010101010101010101", r);
    end
  endtask

  task automatic test_full_state();
    logic [127:0] r; int lat; bit ok;
    transact(128'h9fdc589d_4d7ebdf8_d5d5d7d6_c6c6c6c6, r, lat, ok);
    checks++; if (!ok || lat !== 4) begin errors++; $display("FAIL full_latency got=%0d ok=%b exp=4", lat, ok); end
    checks++; if (r !== 128'hf20a225c_2d26314c_d4d4d4d5_c6c6c6c6) begin
      errors++; $display("FAIL full_data got=%h exp=f20a225c2d26314cd4d4d4d5c6c6c6c6", r);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, exp; bit seen;
    d = rand128();
    exp = ref_inv_mix(d);
    @(negedge clk);
    in_data = d; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_timeout got=none exp=out_valid"); end
    in_data = ~d; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_data !== exp) begin errors++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, out_data, exp); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== exp) begin errors++; $display("FAIL bp_held_data got=%h exp=%h", out_data, exp); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] v [2];
    logic [127:0] outs [$];
    int acc [2];
    int n_acc;
    v[0] = rand128(); v[1] = rand128();
    n_acc = 0; acc[0] = -1; acc[1] = -1;
    @(negedge clk);
    in_data = v[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40 && outs.size() < 2; i++) begin
      bit accepting;
      accepting = in_valid && in_ready;
      if (out_valid) outs.push_back(out_data);
      if (accepting) begin acc[n_acc] = i; n_acc++; end
      @(posedge clk);
      #1;
      if (accepting && n_acc == 1) in_data = v[1];
      if (accepting && n_acc == 2) in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (n_acc !== 2 || acc[1] - acc[0] !== 6) begin
      errors++; $display("FAIL b2b_interval got=%0d accepts=%0d exp=6", acc[1] - acc[0], n_acc);
    end
    checks++; if (outs.size() !== 2) begin
      errors++; $display("FAIL b2b_count got=%0d exp=2", outs.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++; if (outs[k] !== ref_inv_mix(v[k])) begin
          errors++; $display("FAIL b2b_data%0d got=%h exp=%h", k, outs[k], ref_inv_mix(v[k]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] r; int lat; bit ok;
    @(negedge clk);
    in_data = rand128(); in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL midrst_data got=%h exp=0", out_data); end
    #1 rst_n = 1'b1;
    transact(128'h8e4da1bc_01010101_01010101_01010101, r, lat, ok);
    checks++; if (!ok || r !== 128'hdb135345_01010101_01010101_01010101) begin
      errors++; $display("FAIL midrst_after got=%h exp=db135345010101010101010101010101", r);
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] orig, r; int lat; bit ok;
    for (int n = 0; n < 1000; n++) begin
      orig = rand128();
      transact(ref_fwd_mix(orig), r, lat, ok);
      checks++; if (!ok || r !== orig) begin
        errors++; $display("FAIL round_trip n=%0d got=%h exp=%h", n, r, orig);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_column();
    test_full_state();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
